// File: rtl/pong_match_ctrl_if.sv
// Control/status bundle between the pong match controller and the game datapath.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic       point_p1;
  logic       point_p2;
  logic       ball_enable;
  logic       serve;
  logic       serve_dir;
  logic       paddles_enable;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output frame_tick, start, pause, point_p1, point_p2,
    input  ball_enable, serve, serve_dir, paddles_enable,
           p1_score, p2_score, winner, state
  );

  modport slave (
    input  frame_tick, start, pause, point_p1, point_p2,
    output ball_enable, serve, serve_dir, paddles_enable,
           p1_score, p2_score, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: idle -> serve countdown -> rally -> post-point hold -> game over.
// All outputs come straight from registers.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic             clk,
  input  logic             reset,
  pong_match_ctrl_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE = 8'(SERVE_FRAMES);
  localparam logic [7:0] LP_POINT = 8'(POINT_FRAMES);

  state_t     r_state, w_state_n;
  logic [7:0] r_cnt, w_cnt_n;
  logic [3:0] r_p1, w_p1_n, r_p2, w_p2_n;
  logic [1:0] r_win, w_win_n;
  logic       r_sd, w_sd_n;
  logic       r_serve, w_serve_n;
  logic       r_be, w_be_n;
  logic       r_pe, w_pe_n;
  logic       r_start_q, r_arm;

  logic       w_rise, w_tick;
  logic [7:0] w_cnt_inc;
  logic [3:0] w_p1_inc, w_p2_inc;

  // r_arm stays low until start has been seen low once after reset, so a
  // button held through reset release never counts as a press.
  assign w_rise    = io_bus.start & ~r_start_q & r_arm;
  assign w_tick    = io_bus.frame_tick & ~io_bus.pause;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_p1_inc  = r_p1 + 4'd1;
  assign w_p2_inc  = r_p2 + 4'd1;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_p1_n    = r_p1;
    w_p2_n    = r_p2;
    w_win_n   = r_win;
    w_sd_n    = r_sd;
    w_serve_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_p1_n    = 4'd0;
          w_p2_n    = 4'd0;
          w_win_n   = 2'b00;
          w_sd_n    = 1'b0;
          w_cnt_n   = 8'd0;
          w_state_n = S_SERVE;
        end
      end
      S_SERVE: begin
        if (w_tick) begin
          if (w_cnt_inc == LP_SERVE) begin
            w_cnt_n   = 8'd0;
            w_serve_n = 1'b1;
            w_state_n = S_PLAY;
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end
      end
      S_PLAY: begin
        w_cnt_n = 8'd0;
        if (io_bus.point_p1 && io_bus.point_p2) begin
          w_state_n = S_POINT;
        end else if (io_bus.point_p1) begin
          w_p1_n = w_p1_inc;
          w_sd_n = 1'b1;
          if (w_p1_inc == LP_WIN) begin
            w_win_n   = 2'b01;
            w_state_n = S_OVER;
          end else begin
            w_state_n = S_POINT;
          end
        end else if (io_bus.point_p2) begin
          w_p2_n = w_p2_inc;
          w_sd_n = 1'b0;
          if (w_p2_inc == LP_WIN) begin
            w_win_n   = 2'b10;
            w_state_n = S_OVER;
          end else begin
            w_state_n = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (w_tick) begin
          if (w_cnt_inc == LP_POINT) begin
            w_cnt_n   = 8'd0;
            w_state_n = S_SERVE;
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end
      end
      S_OVER: begin
        if (w_rise) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    w_be_n = (w_state_n == S_PLAY) && !io_bus.pause;
    w_pe_n = (w_state_n == S_SERVE) || (w_state_n == S_PLAY) || (w_state_n == S_POINT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_p1      <= 4'd0;
      r_p2      <= 4'd0;
      r_win     <= 2'b00;
      r_sd      <= 1'b0;
      r_serve   <= 1'b0;
      r_be      <= 1'b0;
      r_pe      <= 1'b0;
      r_start_q <= 1'b0;
      r_arm     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_p1      <= w_p1_n;
      r_p2      <= w_p2_n;
      r_win     <= w_win_n;
      r_sd      <= w_sd_n;
      r_serve   <= w_serve_n;
      r_be      <= w_be_n;
      r_pe      <= w_pe_n;
      r_start_q <= io_bus.start;
      if (!io_bus.start) r_arm <= 1'b1;
    end
  end

  assign io_bus.state          = r_state;
  assign io_bus.p1_score       = r_p1;
  assign io_bus.p2_score       = r_p2;
  assign io_bus.winner         = r_win;
  assign io_bus.serve_dir      = r_sd;
  assign io_bus.serve          = r_serve;
  assign io_bus.ball_enable    = r_be;
  assign io_bus.paddles_enable = r_pe;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed scoreboard bench for pong_match_ctrl (WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2).
module tb_pong_match_ctrl;

  logic clk;
  logic reset;
  pong_match_ctrl_if ifc();

  pong_match_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] snap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Expected score-side state, updated by the directed steps below.
  logic [3:0] xp1, xp2;
  logic [1:0] xw;
  logic       xsd;

  function automatic logic [16:0] pack(logic [2:0] s, logic [3:0] a, logic [3:0] b,
                                       logic [1:0] w, logic be, logic sv, logic sd, logic pe);
    return {s, a, b, w, be, sv, sd, pe};
  endfunction

  function automatic logic [16:0] observed();
    return {ifc.state, ifc.p1_score, ifc.p2_score, ifc.winner,
            ifc.ball_enable, ifc.serve, ifc.serve_dir, ifc.paddles_enable};
  endfunction

  task automatic push(input string tag, input logic [2:0] s, input logic be, input logic sv);
    exp_t e;
    logic pe;
    pe = (s == 3'd1) || (s == 3'd2) || (s == 3'd3);
    e.tag  = tag;
    e.snap = pack(s, xp1, xp2, xw, be, sv, xsd, pe);
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [16:0] o;
    e = exp_q.pop_front();
    o = observed();
    total++;
    assert (o === e.snap) else begin
      bad++;
      $error("FAIL %s: observed=%05h expected=%05h", e.tag, o, e.snap);
    end
  endtask

  // Drive inputs for one cycle, queue the post-edge expectation, then compare.
  task automatic go(input string tag, input logic ft, input logic st, input logic pa,
                    input logic a, input logic b,
                    input logic [2:0] es, input logic ebe, input logic esv);
    ifc.frame_tick = ft;
    ifc.start      = st;
    ifc.pause      = pa;
    ifc.point_p1   = a;
    ifc.point_p2   = b;
    push(tag, es, ebe, esv);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // POINT hold (2 ticks) -> SERVE (2 ticks) -> serve pulse into PLAY, one idle PLAY cycle.
  task automatic point_cycle(input string tag);
    go({tag, "_pt1"},  1, 0, 0, 0, 0, 3'd3, 0, 0);
    go({tag, "_pt2"},  1, 0, 0, 0, 0, 3'd1, 0, 0);
    go({tag, "_sv1"},  1, 0, 0, 0, 0, 3'd1, 0, 0);
    go({tag, "_sv2"},  1, 0, 0, 0, 0, 3'd2, 1, 1);
    go({tag, "_play"}, 0, 0, 0, 0, 0, 3'd2, 1, 0);
  endtask

  initial begin
    xp1 = 0; xp2 = 0; xw = 0; xsd = 0;
    ifc.frame_tick = 0; ifc.start = 0; ifc.pause = 0; ifc.point_p1 = 0; ifc.point_p2 = 0;
    reset = 1'b1;
    #2;
    push("reset_state", 3'd0, 0, 0);
    pop_check();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;

    // start and first serve
    go("idle",        0, 0, 0, 0, 0, 3'd0, 0, 0);
    go("start_rise",  0, 1, 0, 0, 0, 3'd1, 0, 0);
    go("serve_t1",    1, 1, 0, 0, 0, 3'd1, 0, 0);
    go("serve_t2",    1, 0, 0, 0, 0, 3'd2, 1, 1);
    go("play",        0, 0, 0, 0, 0, 3'd2, 1, 0);
    go("start_play",  0, 1, 0, 0, 0, 3'd2, 1, 0);

    // P1 point
    xp1 = 1; xsd = 1;
    go("p1_point",    0, 0, 0, 1, 0, 3'd3, 0, 0);
    point_cycle("p1");

    // simultaneous points replay the rally
    go("both_points", 0, 0, 0, 1, 1, 3'd3, 0, 0);
    point_cycle("both");

    // pause in PLAY gates the ball
    go("pause_hi",    0, 0, 1, 0, 0, 3'd2, 0, 0);
    go("pause_lo",    0, 0, 0, 0, 0, 3'd2, 1, 0);

    // P2 wins the match
    xp2 = 1; xsd = 0;
    go("p2_point1",   0, 0, 0, 0, 1, 3'd3, 0, 0);
    point_cycle("p2a");
    xp2 = 2;
    go("p2_point2",   0, 0, 0, 0, 1, 3'd3, 0, 0);
    point_cycle("p2b");
    xp2 = 3; xw = 2'b10;
    go("p2_win",      0, 0, 0, 0, 1, 3'd4, 0, 0);
    go("over_p1_ign", 0, 0, 0, 1, 0, 3'd4, 0, 0);
    go("over_p2_ign", 1, 0, 0, 0, 1, 3'd4, 0, 0);
    go("over_to_idle",0, 1, 0, 0, 0, 3'd0, 0, 0);
    go("idle_held",   0, 0, 0, 0, 1, 3'd0, 0, 0);
    xp1 = 0; xp2 = 0; xw = 0; xsd = 0;
    go("restart",     0, 1, 0, 0, 0, 3'd1, 0, 0);

    // paused ticks are dropped in SERVE
    for (int i = 0; i < 5; i++)
      go("serve_paused", 1, 0, 1, 0, 0, 3'd1, 0, 0);
    go("serve_unp_t1",1, 0, 0, 0, 0, 3'd1, 0, 0);
    go("serve_unp_t2",1, 0, 0, 0, 0, 3'd2, 1, 1);

    // reach p1_score=2 in PLAY
    xp1 = 1; xsd = 1;
    go("p1_a",        0, 0, 0, 1, 0, 3'd3, 0, 0);
    point_cycle("p1a");
    xp1 = 2;
    go("p1_b",        0, 0, 0, 1, 0, 3'd3, 0, 0);
    point_cycle("p1b");

    // asynchronous reset mid-rally with start held high
    ifc.start = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    xp1 = 0; xp2 = 0; xw = 0; xsd = 0;
    push("async_reset", 3'd0, 0, 0);
    pop_check();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    go("held_start1", 0, 1, 0, 0, 0, 3'd0, 0, 0);
    go("held_start2", 1, 1, 0, 1, 0, 3'd0, 0, 0);
    go("start_drop",  0, 0, 0, 0, 0, 3'd0, 0, 0);
    go("start_again", 0, 1, 0, 0, 0, 3'd1, 0, 0);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim_time=%0t limit=100000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win the match (legal range 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frame ticks spent in SERVE before the ball launches (legal range 1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 90, frame ticks of post-point hold (legal range 1..255).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  synchronous level from the start button.
- pause  in  1  synchronous level; freezes play while high.
- point_p1  in  1  one-cycle pulse; P1 scored.
- point_p2  in  1  one-cycle pulse; P2 scored.
- ball_enable  out  1  ball may move.
- serve  out  1  one-cycle pulse; ball re-centres and launches.
- serve_dir  out  1  launch direction: 0 toward P1 (left), 1 toward P2 (right).
- paddles_enable  out  1  paddle input accepted.
- p1_score  out  4  P1 points.
- p2_score  out  4  P2 points.
- winner  out  2  00 none, 01 P1, 10 P2.
- state  out  3  encoded FSM state.

Function
REQ-005 SHALL implement the states IDLE=0, SERVE=1, PLAY=2, POINT=3 and OVER=4; codes 5..7 SHALL go to IDLE on the next clk.
REQ-006 SHALL register all outputs, so every output changes on the first clk after the event that causes it.
REQ-007 SHALL detect a start rise as start high this cycle and low the previous cycle; the history register SHALL reset to 0.
REQ-008 IDLE: a start rise SHALL clear p1_score, p2_score and winner, set serve_dir=0, clear the frame counter and enter SERVE.
REQ-009 SERVE: each frame_tick while pause is low SHALL increment the 8-bit frame counter; on the tick that makes the count equal SERVE_FRAMES the block SHALL enter PLAY, assert serve for exactly that one cycle and clear the counter.
REQ-010 PLAY: ball_enable SHALL equal 1 when pause is low and 0 when pause is high, with the registered one-cycle lag.
REQ-011 PLAY with point_p1 only: the block SHALL increment p1_score and set serve_dir=1; if the new score equals WIN_SCORE it SHALL set winner=01 and enter OVER, otherwise it SHALL enter POINT.
REQ-012 PLAY with point_p2 only: the block SHALL act symmetrically (increment p2_score, serve_dir=0, winner=10 on reaching WIN_SCORE).
REQ-013 PLAY with point_p1 and point_p2 in the same cycle: neither score SHALL change, serve_dir SHALL be held, and the block SHALL enter POINT (replayed rally).
REQ-014 point_p1 and point_p2 SHALL be ignored in every state except PLAY.
REQ-015 POINT: ball_enable SHALL be 0 and frame ticks SHALL be counted as in SERVE; on reaching POINT_FRAMES the block SHALL enter SERVE with the counter cleared.
REQ-016 OVER: scores, winner and ball_enable=0 SHALL be held; a start rise SHALL enter IDLE without clearing scores (they clear on the next IDLE->SERVE).
REQ-017 paddles_enable SHALL be 1 in SERVE, PLAY and POINT and 0 in IDLE and OVER; pause SHALL NOT affect it.
REQ-018 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-019 frame_tick received while pause is high SHALL be dropped, not deferred.
REQ-020 A start rise in SERVE, PLAY or POINT SHALL have no effect.

Reset
REQ-021 While reset is high, the block SHALL immediately and asynchronously force: state=IDLE, p1_score=0, p2_score=0, winner=00, ball_enable=0, serve=0, serve_dir=0, paddles_enable=0, frame counter=0 and start history=0.
REQ-022 Reset asserted mid-rally SHALL abort the rally with no serve pulse, and the first state change after release SHALL require a new start rise.

Verification (bench parameters: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2)
REQ-023 Reset, then start rise, then 2 frame_ticks -> state goes 0->1->2; serve is high exactly 1 cycle; ball_enable=1 and serve_dir=0.
REQ-024 In PLAY, point_p1 pulse -> p1_score=1, serve_dir=1, state=3; after 2 ticks state=1; after 2 more ticks serve pulses and state=2.
REQ-025 In PLAY, point_p1 and point_p2 in the same cycle -> scores unchanged, state=3, serve_dir unchanged.
REQ-026 Three point_p2 wins -> p2_score=3, winner=10, state=4, ball_enable=0; further point pulses are ignored; a start rise gives state=0 with the score still 3; a second start rise gives scores 0 and state=1.
REQ-027 In SERVE, pause high across 5 frame_ticks -> counter does not advance and no serve pulse; after pause goes low, 2 ticks are still needed to reach PLAY.
REQ-028 Reset pulse asserted during PLAY with p1_score=2 -> all outputs at their reset values within the same cycle; start held high through reset release does not leave IDLE until start drops and rises again.
